peak_tracker: RTL and testbench

Downstream of the FFT max-bin detector. It captures each reported peak bin (maxbin, qualified by the one-cycle detectdone pulse) into a DEPTH-entry history. It produces a moving-average bin, a frequency estimate in Hz, and a "locked" flag when the recent peaks agree within a tolerance. Its outputs feed the display/control logic.

---
 rtl/peak_tracker_pkg.sv | 23 ++
 rtl/peak_tracker_bin_history.sv | 32 +++
 rtl/peak_tracker.sv | 170 +++++++++++++++++
 tb/tb_peak_tracker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_tracker_pkg.sv
// peak_tracker_pkg: shared state encoding, sizing constants and helpers
// for the peak tracker and its history ring.
package peak_tracker_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      SCAN    = 2'd2,
      CONVERT = 2'd3
   } state_t;

   localparam int DEPTH_DEF  = 4;
   localparam int LOG2_DEPTH = $clog2(DEPTH_DEF);
   localparam int SUM_W      = 10 + LOG2_DEPTH;

   // consecutive outlier rejects that force a history flush
   localparam logic [1:0] REJECT_LIMIT = 2'd3;

   function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/peak_tracker_bin_history.sv
// bin_history: DEPTH x 10-bit register ring. One write port, a read of the
// entry about to be overwritten (at wptr) and an indexed read for scanning.
module bin_history #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          we,
   input  logic [AW-1:0] wptr,
   input  logic [9:0]    data,
   input  logic [AW-1:0] idx,
   output logic [9:0]    old_entry,
   output logic [9:0]    rd_entry
);

   logic [9:0] hist [DEPTH];

   // entry storage; reset and flush both empty the ring
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         hist <= '{default: '0};
      end else if (we) begin
         hist[wptr] <= data;
      end
   end

   assign old_entry = hist[wptr];
   assign rd_entry  = hist[idx];

endmodule

// File: rtl/peak_tracker.sv
// peak_tracker: captures detector peak bins into a history ring and reports
// a moving-average bin, its frequency in Hz and a lock flag.
// Optional build macro PEAK_TRACKER_OUTLIER_EN enables outlier rejection
// with a flush after REJECT_LIMIT consecutive rejects.
module peak_tracker
   import peak_tracker_pkg::*;
#(
   parameter int DEPTH     = DEPTH_DEF,
   parameter int TOL       = 2,
   parameter int BIN_HZ_Q4 = 750
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        detectdone,
   input  logic [9:0]  maxbin,
   output logic        update,
   output logic [9:0]  avgbin,
   output logic [15:0] freq_hz,
   output logic        valid,
   output logic        locked,
   output logic        overrun
);

   localparam int             AW    = $clog2(DEPTH);
   localparam int             SW    = 10 + AW;
   localparam logic [AW:0]    FULL  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]  LAST  = AW'(DEPTH - 1);
   localparam logic [9:0]     TOL10 = 10'(TOL);

   state_t        state, state_next;
   logic [9:0]    sample;
   logic [AW-1:0] wptr, idx;
   logic [AW:0]   fill, fill_inc;
   logic [SW-1:0] sum;
   logic [9:0]    avg, old_entry, rd_entry;
   logic          spread_ok;
   logic          take, flush;

   assign avg = sum[SW-1:AW];

`ifdef PEAK_TRACKER_OUTLIER_EN
   localparam logic [9:0] OUT_LIM = 10'(4 * TOL);
   logic [1:0] rej_cnt;
   logic       rej_inc;
   logic       outlier;
   assign outlier = valid && (abs_diff10(maxbin, avgbin) > OUT_LIM);
`endif

   bin_history #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_hist (
      .clk       (clk),
      .reset     (reset),
      .clr       (flush),
      .we        (state == WRITE),
      .wptr      (wptr),
      .data      (sample),
      .idx       (idx),
      .old_entry (old_entry),
      .rd_entry  (rd_entry)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // next-state, sample acceptance and flush decision
   always_comb begin
      state_next = state;
      take       = 1'b0;
      flush      = 1'b0;
`ifdef PEAK_TRACKER_OUTLIER_EN
      rej_inc    = 1'b0;
`endif
      fill_inc   = (fill == FULL) ? FULL : fill + 1'b1;
      unique case (state)
         IDLE: begin
            if (detectdone) begin
`ifdef PEAK_TRACKER_OUTLIER_EN
               if (outlier) begin
                  // last allowed reject: flush and restart history with this sample
                  if (rej_cnt == REJECT_LIMIT - 2'd1) begin
                     flush      = 1'b1;
                     take       = 1'b1;
                     state_next = WRITE;
                  end else begin
                     rej_inc = 1'b1;
                  end
               end else begin
                  take       = 1'b1;
                  state_next = WRITE;
               end
`else
               take       = 1'b1;
               state_next = WRITE;
`endif
            end
         end
         WRITE:   state_next = (fill_inc == FULL) ? SCAN : CONVERT;
         SCAN:    if (idx == LAST) state_next = CONVERT;
         CONVERT: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // datapath: history bookkeeping, spread scan and output refresh
   always_ff @(posedge clk) begin
      if (reset) begin
         sample    <= '0;
         wptr      <= '0;
         idx       <= '0;
         fill      <= '0;
         sum       <= '0;
         spread_ok <= 1'b0;
         update    <= 1'b0;
         avgbin    <= '0;
         freq_hz   <= '0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         update <= 1'b0;
         if (detectdone && (state != IDLE)) overrun <= 1'b1;
         unique case (state)
            IDLE: begin
               if (take) sample <= maxbin;
               if (flush) begin
                  wptr   <= '0;
                  fill   <= '0;
                  sum    <= '0;
                  valid  <= 1'b0;
                  locked <= 1'b0;
               end
            end
            WRITE: begin
               sum       <= sum - {{AW{1'b0}}, old_entry} + {{AW{1'b0}}, sample};
               wptr      <= wptr + 1'b1;
               fill      <= fill_inc;
               idx       <= '0;
               spread_ok <= 1'b1;
            end
            SCAN: begin
               if (abs_diff10(rd_entry, avg) > TOL10) spread_ok <= 1'b0;
               idx <= idx + 1'b1;
            end
            CONVERT: begin
               avgbin  <= avg;
               freq_hz <= 16'(({10'd0, avg} * 20'(BIN_HZ_Q4)) >> 4);
               valid   <= (fill == FULL);
               locked  <= (fill == FULL) && spread_ok;
               update  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef PEAK_TRACKER_OUTLIER_EN
   // consecutive-reject counter; any accepted sample clears it
   always_ff @(posedge clk) begin
      if (reset)        rej_cnt <= '0;
      else if (take)    rej_cnt <= '0;
      else if (rej_inc) rej_cnt <= rej_cnt + 2'd1;
   end
`endif

endmodule

// File: tb/tb_peak_tracker.sv
// tb_peak_tracker: table vectors, hand-written corner sequences and random
// samples checked against a queue-based model of the peak history.
module tb_peak_tracker;

   localparam int DEPTH  = 4;
   localparam int TOL    = 2;
   localparam int BIN_HZ = 750;

   logic        clk = 1'b0;
   logic        reset, detectdone;
   logic [9:0]  maxbin;
   logic        update, valid, locked, overrun;
   logic [9:0]  avgbin;
   logic [15:0] freq_hz;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   peak_tracker #(
      .DEPTH     (DEPTH),
      .TOL       (TOL),
      .BIN_HZ_Q4 (BIN_HZ)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .detectdone (detectdone),
      .maxbin     (maxbin),
      .update     (update),
      .avgbin     (avgbin),
      .freq_hz    (freq_hz),
      .valid      (valid),
      .locked     (locked),
      .overrun    (overrun)
   );

   // reference model: the last DEPTH accepted samples
   int hq[$];
   int m_valid, m_avg, m_rej;

   typedef struct {
      int bin;
      int avg;
      int freq;
      int vld;
      int lck;
   } vec_t;
   vec_t tbl[$];

   function automatic int absdiff(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      hq.delete();
      m_valid = 0;
      m_avg   = 0;
      m_rej   = 0;
   endtask

   function automatic void model_accept(input int b, output int av, output int fq,
                                        output int vl, output int lk);
      int s = 0;
      hq.push_back(b);
      if (hq.size() > DEPTH) void'(hq.pop_front());
      foreach (hq[i]) s += hq[i];
      av = s / DEPTH;
      fq = (av * BIN_HZ) / 16;
      vl = (hq.size() == DEPTH) ? 1 : 0;
      lk = vl;
      foreach (hq[i]) if (absdiff(hq[i], av) > TOL) lk = 0;
      m_valid = vl;
      m_avg   = av;
   endfunction

   task automatic drive_pulse(input int b);
      @(negedge clk);
      detectdone = 1'b1;
      maxbin     = 10'(b);
      @(posedge clk);
      #1;
      detectdone = 1'b0;
      maxbin     = 10'($urandom_range(0, 1023));
   endtask

   task automatic wait_update(input string nm, input int start, input int lat, input int av,
                              input int fq, input int vl, input int lk);
      int c = start;
      while (update !== 1'b1 && c < 40) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk({nm, "_lat"}, c, lat);
      if (update === 1'b1) begin
         chk({nm, "_avg"}, int'(avgbin), av);
         chk({nm, "_freq"}, int'(freq_hz), fq);
         chk({nm, "_valid"}, int'(valid), vl);
         chk({nm, "_locked"}, int'(locked), lk);
         @(posedge clk);
         #1;
         chk({nm, "_pulse"}, int'(update), 0);
      end
   endtask

   task automatic expect_quiet(input string nm, input int n);
      int seen = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (update === 1'b1) seen++;
      end
      chk(nm, seen, 0);
   endtask

   task automatic send(input int b, input string nm);
      int av, fq, vl, lk;
      bit rej = 1'b0;
`ifdef PEAK_TRACKER_OUTLIER_EN
      if (m_valid != 0 && absdiff(b, m_avg) > 4 * TOL) begin
         m_rej++;
         if (m_rej < 3) rej = 1'b1;
         else begin
            hq.delete();
            m_rej   = 0;
            m_valid = 0;
         end
      end else begin
         m_rej = 0;
      end
`endif
      drive_pulse(b);
      if (rej) begin
         expect_quiet({nm, "_rej"}, DEPTH + 4);
         return;
      end
      model_accept(b, av, fq, vl, lk);
      wait_update(nm, 0, (vl != 0) ? DEPTH + 2 : 2, av, fq, vl, lk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int av, fq, vl, lk, center, b;

      reset      = 1'b1;
      detectdone = 1'b0;
      maxbin     = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_update", int'(update), 0);
      chk("rst_avg", int'(avgbin), 0);
      chk("rst_freq", int'(freq_hz), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_overrun", int'(overrun), 0);
      @(negedge clk);
      reset = 1'b0;

      // fill-up and small-spread vectors
      tbl.push_back('{40, 10,  468, 0, 0});
      tbl.push_back('{40, 20,  937, 0, 0});
      tbl.push_back('{40, 30, 1406, 0, 0});
      tbl.push_back('{40, 40, 1875, 1, 1});
      tbl.push_back('{41, 40, 1875, 1, 1});
      tbl.push_back('{39, 40, 1875, 1, 1});
      tbl.push_back('{42, 40, 1875, 1, 1});
`ifndef PEAK_TRACKER_OUTLIER_EN
      tbl.push_back('{50, 43, 2015, 1, 0});
`endif
      for (int i = 0; i < tbl.size(); i++) begin
         drive_pulse(tbl[i].bin);
         model_accept(tbl[i].bin, av, fq, vl, lk);
         wait_update($sformatf("tbl%0d", i), 0, (tbl[i].vld != 0) ? DEPTH + 2 : 2,
                     tbl[i].avg, tbl[i].freq, tbl[i].vld, tbl[i].lck);
      end

      // detectdone during SCAN is dropped and sets sticky overrun
      chk("ovr_pre", int'(overrun), 0);
      drive_pulse(41);
      model_accept(41, av, fq, vl, lk);
      @(posedge clk);
      #1;
      @(negedge clk);
      detectdone = 1'b1;
      maxbin     = 10'd700;
      @(posedge clk);
      #1;
      detectdone = 1'b0;
      wait_update("ovr", 2, DEPTH + 2, av, fq, vl, lk);
      chk("ovr_set", int'(overrun), 1);
      send(40, "ovr_next");
      chk("ovr_sticky", int'(overrun), 1);

      // reset during SCAN aborts without an update
      drive_pulse(42);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      do_reset();
      expect_quiet("rst_scan_quiet", 12);
      chk("rst_scan_avg", int'(avgbin), 0);
      chk("rst_scan_freq", int'(freq_hz), 0);
      chk("rst_scan_valid", int'(valid), 0);
      chk("rst_scan_locked", int'(locked), 0);
      chk("rst_scan_overrun", int'(overrun), 0);
      send(40, "post_rst0");
      send(44, "post_rst1");
      send(38, "post_rst2");

      // full-scale bin
      do_reset();
      repeat (4) send(1023, "max");
      chk("max_freq", int'(freq_hz), 47953);

`ifdef PEAK_TRACKER_OUTLIER_EN
      do_reset();
      repeat (4) send(40, "ol_fill");
      send(60, "ol_r1");
      send(60, "ol_r2");
      send(60, "ol_flush");
      chk("ol_flush_avg", int'(avgbin), 15);
      chk("ol_flush_valid", int'(valid), 0);
      do_reset();
      repeat (4) send(40, "ol_fill2");
      send(60, "ol_a1");
      send(60, "ol_a2");
      send(40, "ol_ok");
      send(60, "ol_b1");
      send(60, "ol_b2");
`endif

      // randomized samples clustered around a drifting centre
      do_reset();
      center = 500;
      for (int i = 0; i < 48; i++) begin
         if (i % 8 == 0) center = int'($urandom_range(3, 1020));
         if ($urandom_range(0, 5) == 0) b = int'($urandom_range(0, 1023));
         else b = center + int'($urandom_range(0, 6)) - 3;
         send(b, $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
